// File: rtl/sram_sp_be_init_if.sv
// Request/response bundle for the single-port byte-enable SRAM.
// The master drives access requests; the slave (memory) returns read data and status.
interface sram_sp_be_init_if #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DATA_W = 32
);
    localparam int unsigned BE_W = DATA_W / 8;

    logic              req;
    logic              wren;
    logic [ADDR_W-1:0] addr;
    logic [BE_W-1:0]   be;
    logic [DATA_W-1:0] data;
    logic [DATA_W-1:0] q;
    logic              q_valid;
    logic              rd_err;
    logic              init_busy;

    modport master (
        output req, wren, addr, be, data,
        input  q, q_valid, rd_err, init_busy
    );

    modport slave (
        input  req, wren, addr, be, data,
        output q, q_valid, rd_err, init_busy
    );
endinterface

// File: rtl/sram_sp_be_init.sv
// Single-port synchronous SRAM with byte-lane writes, 1- or 2-cycle read latency,
// a post-reset clear sequencer and out-of-range address detection.
module sram_sp_be_init #(
    parameter int unsigned ADDR_W   = 10,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned DEPTH    = 1024,
    parameter int unsigned RD_LAT   = 1,
    parameter int unsigned INIT_CLR = 1
) (
    input  logic               clk,
    input  logic               rst,
    sram_sp_be_init_if.slave   bus
);
    localparam int unsigned BE_W  = DATA_W / 8;
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [IDX_W-1:0]  r_clr_cnt;
    logic [IDX_W-1:0]  w_clr_cnt_nxt;
    logic              w_clr_we;

    logic [DATA_W-1:0] r_mem [DEPTH];

    logic              w_in_range;
    logic [IDX_W-1:0]  w_idx;
    logic              w_acc;
    logic              w_wr_acc;
    logic              w_rd_acc;

    logic [DATA_W-1:0] r_rd_q;
    logic              r_rd_vld;
    logic              r_rd_err;

    logic [DATA_W-1:0] w_out_q;
    logic              w_out_vld;
    logic              w_out_err;

    // A full address space has no out-of-range words.
    generate
        if (DEPTH >= 2**ADDR_W) begin : g_full_range
            assign w_in_range = 1'b1;
        end else begin : g_part_range
            assign w_in_range = (bus.addr < ADDR_W'(DEPTH));
        end
    endgenerate

    assign w_idx    = IDX_W'(bus.addr);
    assign w_acc    = bus.req & ~rst & (r_state == ST_READY);
    assign w_wr_acc = w_acc & bus.wren;
    assign w_rd_acc = w_acc & ~bus.wren;

    // Clear sequencer state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= (INIT_CLR != 0) ? ST_CLEAR : ST_READY;
            r_clr_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_clr_cnt <= w_clr_cnt_nxt;
        end
    end

    // Clear sequencer next state: one zeroed word per cycle, leave on the last word.
    always_comb begin
        w_state_nxt   = r_state;
        w_clr_cnt_nxt = r_clr_cnt;
        w_clr_we      = 1'b0;
        case (r_state)
            ST_CLEAR: begin
                w_clr_we = 1'b1;
                if (r_clr_cnt == LAST_IDX) begin
                    w_state_nxt   = ST_READY;
                    w_clr_cnt_nxt = '0;
                end else begin
                    w_clr_cnt_nxt = r_clr_cnt + IDX_W'(1);
                end
            end
            ST_READY: begin
                w_state_nxt = ST_READY;
            end
            default: begin
                w_state_nxt = ST_READY;
            end
        endcase
    end

    // Storage array: clear writes and byte-lane user writes never coincide.
    always_ff @(posedge clk) begin
        if (!rst && w_clr_we) begin
            r_mem[r_clr_cnt] <= '0;
        end else if (w_wr_acc && w_in_range) begin
            for (int unsigned i = 0; i < BE_W; i++) begin
                if (bus.be[i]) begin
                    r_mem[w_idx][8*i +: 8] <= bus.data[8*i +: 8];
                end
            end
        end
    end

    // First read stage; out-of-range reads return zero and flag an error.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_q   <= '0;
            r_rd_vld <= 1'b0;
            r_rd_err <= 1'b0;
        end else begin
            r_rd_vld <= w_rd_acc;
            r_rd_err <= w_rd_acc & ~w_in_range;
            if (w_rd_acc) begin
                r_rd_q <= w_in_range ? r_mem[w_idx] : '0;
            end
        end
    end

    generate
        if (RD_LAT >= 2) begin : g_lat2
            logic [DATA_W-1:0] r_q2;
            logic              r_vld2;
            logic              r_err2;

            // Extra output register stage; data only advances with a valid read.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_q2   <= '0;
                    r_vld2 <= 1'b0;
                    r_err2 <= 1'b0;
                end else begin
                    r_vld2 <= r_rd_vld;
                    r_err2 <= r_rd_err;
                    if (r_rd_vld) begin
                        r_q2 <= r_rd_q;
                    end
                end
            end

            assign w_out_q   = r_q2;
            assign w_out_vld = r_vld2;
            assign w_out_err = r_err2;
        end else begin : g_lat1
            assign w_out_q   = r_rd_q;
            assign w_out_vld = r_rd_vld;
            assign w_out_err = r_rd_err;
        end
    endgenerate

    // Outputs are forced to their reset values for as long as rst is held,
    // which also suppresses a read that completes in the first reset cycle.
    assign bus.q         = rst ? '0 : w_out_q;
    assign bus.q_valid   = w_out_vld & ~rst;
    assign bus.rd_err    = w_out_err & ~rst;
    assign bus.init_busy = rst ? (INIT_CLR != 0) : (r_state == ST_CLEAR);

endmodule

// File: tb/tb_sram_sp_be_init.sv
// Bench for sram_sp_be_init: a 1024-word RD_LAT=1 instance and a 1000-word RD_LAT=2
// instance share one stimulus stream and are checked against a cycle-level memory model.
module tb_sram_sp_be_init;
    localparam int unsigned AW = 10;
    localparam int unsigned DW = 32;

    logic          clk;
    logic          rst;
    logic          req;
    logic          wren;
    logic [AW-1:0] addr;
    logic [3:0]    be;
    logic [31:0]   data;

    sram_sp_be_init_if #(.ADDR_W(AW), .DATA_W(DW)) if0 ();
    sram_sp_be_init_if #(.ADDR_W(AW), .DATA_W(DW)) if1 ();

    assign if0.req  = req;
    assign if0.wren = wren;
    assign if0.addr = addr;
    assign if0.be   = be;
    assign if0.data = data;
    assign if1.req  = req;
    assign if1.wren = wren;
    assign if1.addr = addr;
    assign if1.be   = be;
    assign if1.data = data;

    sram_sp_be_init #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(1024), .RD_LAT(1), .INIT_CLR(1)) u0 (
        .clk (clk),
        .rst (rst),
        .bus (if0.slave)
    );

    sram_sp_be_init #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(1000), .RD_LAT(2), .INIT_CLR(1)) u1 (
        .clk (clk),
        .rst (rst),
        .bus (if1.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- behavioural model ----------------
    int          dep [2] = '{1024, 1000};
    int          lat [2] = '{1, 2};
    logic [31:0] m_mem [2][1024];
    int          m_left [2];
    logic [31:0] m_lastq [2];
    bit          s_v   [2][4];
    logic [31:0] s_q   [2][4];
    bit          s_e   [2][4];
    int          s_tag [2][4];
    int          cyc;
    bit          started;

    int n_chk;
    int n_pass;

    initial begin
        cyc     = 0;
        started = 1'b0;
        for (int k = 0; k < 2; k++) begin
            m_left[k]  = 0;
            m_lastq[k] = '0;
            for (int s = 0; s < 4; s++) s_v[k][s] = 1'b0;
        end
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
            if (rst) started = 1'b1;
            for (int k = 0; k < 2; k++) begin
                if (rst) begin
                    m_left[k]  = dep[k];
                    m_lastq[k] = '0;
                    for (int s = 0; s < 4; s++) s_v[k][s] = 1'b0;
                end else if (m_left[k] > 0) begin
                    m_left[k] = m_left[k] - 1;
                    if (m_left[k] == 0) begin
                        for (int i = 0; i < dep[k]; i++) m_mem[k][i] = '0;
                    end
                end else if (req) begin
                    int a;
                    a = int'(addr);
                    if (wren) begin
                        if (a < dep[k]) begin
                            for (int b = 0; b < 4; b++)
                                if (be[b]) m_mem[k][a][8*b +: 8] = data[8*b +: 8];
                        end
                    end else begin
                        int t;
                        t = cyc + lat[k] - 1;
                        s_v[k][t % 4]   = 1'b1;
                        s_tag[k][t % 4] = t;
                        s_q[k][t % 4]   = (a < dep[k]) ? m_mem[k][a] : 32'h0;
                        s_e[k][t % 4]   = (a >= dep[k]);
                    end
                end
            end
        end
    end

    task automatic chk(input int k, input logic v, input logic e, input logic b, input logic [31:0] q);
        int          s;
        logic        ev;
        logic        ee;
        logic        eb;
        logic [31:0] eq;
        s  = cyc % 4;
        ev = !rst && s_v[k][s] && (s_tag[k][s] == cyc);
        if (ev) m_lastq[k] = s_q[k][s];
        ee = ev && s_e[k][s];
        eb = rst || (m_left[k] > 0);
        eq = rst ? 32'h0 : m_lastq[k];
        n_chk = n_chk + 1;
        if ({v, e, b, q} === {ev, ee, eb, eq})
            n_pass = n_pass + 1;
        else
            $display("FAIL cycle u%0d @%0d: got vld=%b err=%b busy=%b q=%h want vld=%b err=%b busy=%b q=%h",
                     k, cyc, v, e, b, q, ev, ee, eb, eq);
    endtask

    // Per-cycle comparison against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (started) begin
                chk(0, if0.q_valid, if0.rd_err, if0.init_busy, if0.q);
                chk(1, if1.q_valid, if1.rd_err, if1.init_busy, if1.q);
            end
        end
    end

    // Record every valid read return for the literal checks.
    logic [31:0] mq0 [$];
    bit          me0 [$];
    int          mc0 [$];
    logic [31:0] mq1 [$];
    bit          me1 [$];
    int          mc1 [$];

    initial begin
        forever begin
            @(negedge clk);
            if (if0.q_valid === 1'b1) begin
                mq0.push_back(if0.q); me0.push_back(if0.rd_err); mc0.push_back(cyc);
            end
            if (if1.q_valid === 1'b1) begin
                mq1.push_back(if1.q); me1.push_back(if1.rd_err); mc1.push_back(cyc);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    task automatic lit(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (act === exp) n_pass = n_pass + 1;
        else $display("FAIL %s: got %h want %h", nm, act, exp);
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        req = 1'b0; wren = 1'b0; be = 4'h0;
    endtask

    task automatic set_rd(input logic [AW-1:0] a);
        req = 1'b1; wren = 1'b0; addr = a; be = 4'h0; data = '0;
    endtask

    task automatic set_wr(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] b);
        req = 1'b1; wren = 1'b1; addr = a; be = b; data = d;
    endtask

    task automatic clr_mon();
        mq0.delete(); me0.delete(); mc0.delete();
        mq1.delete(); me1.delete(); mc1.delete();
    endtask

    task automatic wait_clear(output int c0, output int c1);
        c0 = 0;
        c1 = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (if0.init_busy) c0++;
            if (if1.init_busy) c1++;
            if (!if0.init_busy && !if1.init_busy) break;
        end
    endtask

    initial begin
        int c0;
        int c1;
        int dc;
        n_chk  = 0;
        n_pass = 0;
        rst  = 1'b1;
        addr = '0;
        data = '0;
        idle();
        repeat (3) nxt();
        @(negedge clk);
        lit("rst_busy0", 32'(if0.init_busy), 32'd1);
        lit("rst_qvalid0", 32'(if0.q_valid), 32'd0);
        nxt();
        rst = 1'b0;

        // Initial clear length and cleared contents.
        wait_clear(c0, c1);
        lit("clr_len0", 32'(c0), 32'd1024);
        lit("clr_len1", 32'(c1), 32'd1000);
        nxt();
        clr_mon();
        dc = cyc;
        set_rd(10'd0);    nxt();
        set_rd(10'd511);  nxt();
        set_rd(10'd1023); nxt();
        idle();
        repeat (4) nxt();
        lit("t1_cnt0", 32'(mq0.size()), 32'd3);
        lit("t1_first_cyc0", 32'(mc0[0]), 32'(dc + 1));
        lit("t1_q0_0", mq0[0], 32'h0);
        lit("t1_q0_1", mq0[1], 32'h0);
        lit("t1_q0_2", mq0[2], 32'h0);
        lit("t1_err0_2", 32'(me0[2]), 32'd0);
        lit("t1_err1_2", 32'(me1[2]), 32'd1);

        // Byte-lane merge, read straight after write.
        clr_mon();
        set_wr(10'd5, 32'hDEADBEEF, 4'hF); nxt();
        set_wr(10'd5, 32'h11223344, 4'b0101); nxt();
        set_rd(10'd5); nxt();
        idle();
        repeat (4) nxt();
        lit("t2_q0", mq0[0], 32'hDE22BE44);
        lit("t2_q1", mq1[0], 32'hDE22BE44);

        // Back-to-back reads, in-order returns at each latency.
        set_wr(10'd1, 32'hA, 4'hF); nxt();
        set_wr(10'd2, 32'hB, 4'hF); nxt();
        set_wr(10'd3, 32'hC, 4'hF); nxt();
        idle(); nxt();
        clr_mon();
        dc = cyc;
        set_rd(10'd1); nxt();
        set_rd(10'd2); nxt();
        set_rd(10'd3); nxt();
        idle();
        repeat (4) nxt();
        lit("t3_cnt1", 32'(mq1.size()), 32'd3);
        lit("t3_cyc1_0", 32'(mc1[0]), 32'(dc + 2));
        lit("t3_cyc1_2", 32'(mc1[2]), 32'(dc + 4));
        lit("t3_q1_0", mq1[0], 32'hA);
        lit("t3_q1_1", mq1[1], 32'hB);
        lit("t3_q1_2", mq1[2], 32'hC);
        lit("t3_cyc0_0", 32'(mc0[0]), 32'(dc + 1));

        // Out-of-range write dropped, read flagged (1000-word instance).
        set_wr(10'd1000, 32'h55, 4'hF); nxt();
        idle(); nxt();
        clr_mon();
        set_rd(10'd1000); nxt();
        set_rd(10'd999);  nxt();
        idle();
        repeat (4) nxt();
        lit("t4_q1_0", mq1[0], 32'h0);
        lit("t4_err1_0", 32'(me1[0]), 32'd1);
        lit("t4_q1_1", mq1[1], 32'h0);
        lit("t4_err1_1", 32'(me1[1]), 32'd0);
        lit("t4_q0_0", mq0[0], 32'h55);
        lit("t4_err0_0", 32'(me0[0]), 32'd0);

        // Read in flight when reset arrives is discarded.
        clr_mon();
        set_rd(10'd5); nxt();
        rst = 1'b1;
        idle();
        @(negedge clk);
        lit("t6_qvalid_in_rst", 32'(if0.q_valid), 32'd0);
        lit("t6_q_in_rst", if0.q, 32'h0);
        nxt();
        rst = 1'b0;
        @(negedge clk);
        lit("t6_cnt0", 32'(mq0.size()), 32'd0);
        lit("t6_cnt1", 32'(mq1.size()), 32'd0);
        lit("t6_q0_after", if0.q, 32'h0);
        lit("t6_q1_after", if1.q, 32'h0);

        // Reset mid-clear restarts the whole clear; requests meanwhile are ignored.
        nxt();
        repeat (298) nxt();
        rst = 1'b1;
        set_rd(10'd0);
        nxt();
        rst = 1'b0;
        clr_mon();
        wait_clear(c0, c1);
        lit("t5_clr_len0", 32'(c0), 32'd1024);
        lit("t5_cnt0", 32'(mq0.size()), 32'd0);
        nxt();
        idle();
        repeat (5) nxt();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
